// File: rtl/qs_fifo_pkg.sv
// Shared types for the FIFO pop-side drain: FSM state encoding and output buffer depth.
package qs_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int buf_depth = 2;

endpackage

// File: rtl/qs_skid_buf.sv
// Two-slot valid/ready buffer with wrapping 1-bit pointers and a synchronous clear.
module qs_skid_buf
  import qs_fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [buf_depth];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // The writer only offers data when a slot is free; the guard keeps a full buffer intact anyway.
  assign push      = in_valid && (count != 2'(buf_depth));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (clear) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; out_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/qs_fifo_drain.sv
// Pops words from a FIFO into a 2-entry buffer and streams them out with a per-burst last flag;
// a flush request discards the buffer and empties the FIFO.
module qs_fifo_drain
  import qs_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              fifo_empty_i,
  output logic              fifo_pop_o,
  input  logic [DATA_W-1:0] fifo_pop_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              flush_done_o
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [1:0]        buf_cnt;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              flush_entry;
  logic              push;
  logic              xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Pops depend only on registered state and fifo_empty_i, never on m_ready_i.
  always_comb begin
    state_nxt    = state;
    fifo_pop_o   = 1'b0;
    flush_done_o = 1'b0;
    flush_entry  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_i) begin
          state_nxt   = ST_FLUSH;
          flush_entry = 1'b1;
        end else if (enable_i) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        fifo_pop_o = !fifo_empty_i && (buf_cnt < 2'(buf_depth));
        if (flush_i) begin
          state_nxt   = ST_FLUSH;
          flush_entry = 1'b1;
        end else if (!enable_i) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        fifo_pop_o = !fifo_empty_i;
        if (fifo_empty_i) begin
          state_nxt    = ST_IDLE;
          flush_done_o = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign push      = fifo_pop_o && (state == ST_RUN);
  assign m_valid_o = buf_valid && (state != ST_FLUSH);
  assign xfer      = m_valid_o && m_ready_i;
  assign m_data_o  = m_valid_o ? buf_data : '0;
  assign m_last_o  = m_valid_o && (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign busy_o    = (state != ST_IDLE) || (buf_cnt != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
    end else if (flush_entry) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      if (beat_cnt == CNT_W'(BURST_LEN - 1)) beat_cnt <= '0;
      else                                   beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  qs_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush_entry),
    .in_valid (push),
    .in_data  (fifo_pop_data_i),
    .out_valid(buf_valid),
    .out_ready(xfer),
    .out_data (buf_data),
    .count    (buf_cnt)
  );

endmodule

// File: tb/tb_qs_fifo_drain.sv
// Bench for qs_fifo_drain: queue-based FIFO environment plus a queue-level reference model,
// directed scenarios and a randomized run.
module tb_qs_fifo_drain;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int S_IDLE    = 0;
  localparam int S_RUN     = 1;
  localparam int S_FLUSH   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              fifo_empty_i = 1'b1;
  logic [DATA_W-1:0] fifo_pop_data_i = '0;
  logic              m_ready_i = 1'b0;
  logic              fifo_pop_o;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic              busy_o;
  logic              flush_done_o;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                m_st;
  int                m_beat;
  logic              exp_pop, exp_valid, exp_last, exp_busy, exp_done, obs_pop;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W+4:0] exp_v, obs_v;

  always #5 clk = ~clk;

  qs_fifo_drain #(
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_pop_o     (fifo_pop_o),
    .fifo_pop_data_i(fifo_pop_data_i),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_data_o       (m_data_o),
    .m_last_o       (m_last_o),
    .busy_o         (busy_o),
    .flush_done_o   (flush_done_o)
  );

  task automatic drive_fifo();
    fifo_empty_i    = (fifo_q.size() == 0);
    fifo_pop_data_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic model_reset();
    m_st   = S_IDLE;
    m_beat = 0;
    exp_q.delete();
  endtask

  // Expected outputs for the current cycle, from the model's queue contents and mode.
  task automatic model_eval();
    exp_pop   = (fifo_q.size() != 0) && ((m_st == S_RUN && exp_q.size() < 2) || m_st == S_FLUSH);
    exp_valid = (exp_q.size() != 0) && (m_st != S_FLUSH);
    exp_data  = exp_valid ? exp_q[0] : '0;
    exp_last  = exp_valid && (m_beat == BURST_LEN - 1);
    exp_busy  = (m_st != S_IDLE) || (exp_q.size() != 0);
    exp_done  = (m_st == S_FLUSH) && (fifo_q.size() == 0);
    exp_v     = {exp_pop, exp_valid, exp_last, exp_busy, exp_done, exp_data};
    obs_v     = {fifo_pop_o, m_valid_o, m_last_o, busy_o, flush_done_o, m_data_o};
    obs_pop   = fifo_pop_o;
  endtask

  // Advance one clock: the FIFO reacts to the DUT's pop, the model to the spec rules.
  task automatic tick();
    logic [DATA_W-1:0] w;
    logic              xfer;
    @(posedge clk);
    xfer = exp_valid && m_ready_i;
    w    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    if (obs_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (!reset_n) begin
      model_reset();
    end else if (m_st != S_FLUSH && flush_i) begin
      exp_q.delete();
      m_beat = 0;
      m_st   = S_FLUSH;
    end else begin
      if (xfer) begin
        void'(exp_q.pop_front());
        m_beat = (m_beat + 1) % BURST_LEN;
      end
      if (exp_pop && m_st == S_RUN) exp_q.push_back(w);
      case (m_st)
        S_IDLE:  if (enable_i) m_st = S_RUN;
        S_RUN:   if (!enable_i) m_st = S_IDLE;
        default: if (exp_done) m_st = S_IDLE;
      endcase
    end
    #1 drive_fifo();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable_i  = 1'b0;
    flush_i   = 1'b0;
    m_ready_i = 1'b0;
    fifo_q.delete();
    drive_fifo();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int first_pop, first_valid;
    reset_n = 1'b0;
    model_reset();
    fifo_q = {8'h11, 8'h22, 8'h33};
    drive_fifo();
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      tick();
    end
    reset_n     = 1'b1;
    first_pop   = -1;
    first_valid = -1;
    for (int c = 0; c < 6; c++) begin
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_release c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (fifo_pop_o && first_pop < 0) first_pop = c;
      if (m_valid_o && first_valid < 0) first_valid = c;
      tick();
    end
    checks++;
    if (first_pop !== 1 || first_valid !== 2) begin
      failures++;
      $display("FAIL reset_latency pop_cycle=%0d valid_cycle=%0d exp=1/2", first_pop, first_valid);
    end
  endtask

  task automatic test_streaming();
    int n_xfer, first_x, last_x;
    logic [DATA_W-1:0] lasts[$];
    do_reset();
    fifo_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    drive_fifo();
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    n_xfer = 0; first_x = -1; last_x = -1;
    for (int c = 0; c < 14; c++) begin
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL stream c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (m_valid_o && m_ready_i) begin
        n_xfer++;
        if (first_x < 0) first_x = c;
        last_x = c;
        if (m_last_o) lasts.push_back(m_data_o);
      end
      tick();
    end
    checks++;
    if (n_xfer != 8 || last_x - first_x != 7) begin
      failures++;
      $display("FAIL stream_count xfers=%0d span=%0d exp=8/7", n_xfer, last_x - first_x);
    end
    checks++;
    if (lasts.size() != 2 || lasts[0] !== 8'h04 || lasts[1] !== 8'h08) begin
      failures++;
      $display("FAIL stream_last n=%0d exp last on 04 and 08", lasts.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] sent[$];
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] held;
    do_reset();
    for (int i = 0; i < 12; i++) fifo_q.push_back(DATA_W'($urandom));
    sent = fifo_q;
    drive_fifo();
    enable_i = 1'b1;
    held = '0;
    for (int c = 0; c < 26; c++) begin
      m_ready_i = !(c >= 4 && c <= 8);
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL bp c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c == 4) held = m_data_o;
      if (c > 4 && c <= 8) begin
        checks++;
        if (m_data_o !== held || fifo_pop_o !== (c == 4 ? 1'b1 : 1'b0) || !m_valid_o) begin
          failures++;
          $display("FAIL bp_stall c=%0d data=%h held=%h pop=%b", c, m_data_o, held, fifo_pop_o);
        end
      end
      if (m_valid_o && m_ready_i) got.push_back(m_data_o);
      tick();
    end
    checks++;
    if (got != sent) begin
      failures++;
      $display("FAIL bp_order got_n=%0d exp_n=%0d", got.size(), sent.size());
    end
  endtask

  task automatic test_flush();
    int n_pop, n_done, done_c, n_xfer, last_idx, n_last;
    do_reset();
    for (int i = 0; i < 9; i++) fifo_q.push_back(DATA_W'($urandom));
    drive_fifo();
    enable_i = 1'b1;
    n_pop = 0; n_done = 0; done_c = -1;
    for (int c = 0; c < 14; c++) begin
      m_ready_i = (c == 2);
      flush_i   = (c == 4) || (c == 7);
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL flush c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c >= 5 && fifo_pop_o) n_pop++;
      if (flush_done_o) begin n_done++; done_c = c; end
      tick();
    end
    flush_i = 1'b0;
    checks++;
    if (n_pop != 6 || n_done != 1 || done_c != 11 || fifo_q.size() != 0) begin
      failures++;
      $display("FAIL flush_drain pops=%0d dones=%0d done_c=%0d left=%0d exp=6/1/11/0",
               n_pop, n_done, done_c, fifo_q.size());
    end
    // Beat count restarts after a flush: the 4th beat afterwards carries last.
    for (int i = 0; i < 4; i++) fifo_q.push_back(DATA_W'($urandom));
    drive_fifo();
    m_ready_i = 1'b1;
    n_xfer = 0; last_idx = -1; n_last = 0;
    for (int c = 0; c < 10; c++) begin
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL flush_after c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (m_valid_o && m_ready_i) begin
        n_xfer++;
        if (m_last_o) begin n_last++; last_idx = n_xfer; end
      end
      tick();
    end
    checks++;
    if (n_last != 1 || last_idx != 4) begin
      failures++;
      $display("FAIL flush_beat lasts=%0d idx=%0d exp=1/4", n_last, last_idx);
    end
    // Flush with the FIFO already empty completes after one flush cycle.
    n_done = 0; done_c = -1;
    for (int c = 0; c < 4; c++) begin
      flush_i = (c == 0);
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL flush_empty c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (flush_done_o) begin n_done++; done_c = c; end
      tick();
    end
    flush_i = 1'b0;
    checks++;
    if (n_done != 1 || done_c != 1) begin
      failures++;
      $display("FAIL flush_empty_done dones=%0d c=%0d exp=1/1", n_done, done_c);
    end
  endtask

  task automatic test_enable_toggle();
    logic [DATA_W-1:0] words[$];
    logic [DATA_W-1:0] got[$];
    int off_pops;
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(DATA_W'($urandom));
    words = fifo_q;
    drive_fifo();
    off_pops = 0;
    for (int c = 0; c < 12; c++) begin
      enable_i  = (c == 0) || (c >= 7);
      m_ready_i = (c >= 3);
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL enable c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c >= 2 && c <= 7 && fifo_pop_o) off_pops++;
      if (m_valid_o && m_ready_i && got.size() < 2) got.push_back(m_data_o);
      tick();
    end
    checks++;
    if (off_pops != 0 || got.size() != 2 || got[0] !== words[0] || got[1] !== words[1]) begin
      failures++;
      $display("FAIL enable_seq off_pops=%0d n=%0d exp 0 pops and words %h,%h",
               off_pops, got.size(), words[0], words[1]);
    end
  endtask

  task automatic test_async_reset();
    int n_done;
    do_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(DATA_W'($urandom));
    drive_fifo();
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      flush_i = (c == 0);
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL areset_pre c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c < 3) tick();
    end
    flush_i = 1'b0;
    // Mid-flush, between clock edges.
    #2 reset_n = 1'b0;
    model_reset();
    #1 model_eval();
    checks++;
    if (obs_v !== exp_v || obs_v !== '0) begin
      failures++;
      $display("FAIL areset_now got=%h exp=%h", obs_v, exp_v);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      #1 model_eval();
      if (flush_done_o) n_done++;
    end
    reset_n = 1'b1;
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL areset_done pulses=%0d exp=0", n_done);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 12) fifo_q.push_back(DATA_W'($urandom));
      drive_fifo();
      enable_i  = ($urandom_range(0, 9) != 0);
      m_ready_i = ($urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 39) == 0);
      #1 model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_enable_toggle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
